sobel_window_fetch: RTL and testbench

//   Raster-scan address generator and 3x3 neighbourhood builder. Sits directly downstream of the

---
 rtl/sobel_window_fetch.sv | 171 +++++++++++++++++
 tb/tb_sobel_window_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_fetch : raster-scan address generator and 3x3 window builder   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sobel_window_fetch #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] mem_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  mem_col_o,
  input  logic [DATA_WIDTH-1:0]         mem_pixel_i,
  output logic                          win_valid_o,
  input  logic                          win_ready_i,
  output logic [9*DATA_WIDTH-1:0]       win_data_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_o
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int DW = DATA_WIDTH;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_FETCH_FULL = 2'd1;
  localparam logic [1:0] S_FETCH_COL  = 2'd2;
  localparam logic [1:0] S_OUT        = 2'd3;

  localparam logic [RW-1:0] ROW_ONE       = RW'(1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 2);
  localparam logic [CW-1:0] COL_ONE       = CW'(1);
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 2);
  localparam logic [3:0]    IDX_FULL_LAST = 4'd8;
  localparam logic [3:0]    IDX_COL_LAST  = 4'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [RW-1:0]   cr_q, cr_d, last_row_q, last_row_d;
  logic [CW-1:0]   cc_q, cc_d, last_col_q, last_col_d;
  logic [9*DW-1:0] win_q, win_d;
  logic            done_q, done_d;
  logic [3:0]      row_off, col_off;
  logic            fetching;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start_i) state_d = S_FETCH_FULL;
      S_FETCH_FULL: if (idx_q == IDX_FULL_LAST) state_d = S_OUT;
      S_FETCH_COL:  if (idx_q == IDX_COL_LAST) state_d = S_OUT;
      S_OUT: begin
        if (win_ready_i) begin
          if (cc_q < COL_LAST)      state_d = S_FETCH_COL;
          else if (cr_q < ROW_LAST) state_d = S_FETCH_FULL;
          else                      state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses are combinational during fetch so the returned pixel lands in the same cycle;
  // outside fetch the last driven address is held.
  always_comb begin
    row_off = 4'd0;
    if (idx_q >= 4'd6)      row_off = 4'd2;
    else if (idx_q >= 4'd3) row_off = 4'd1;
    col_off     = idx_q - row_off * 4'd3;
    busy_o      = (state_q != S_IDLE);
    win_valid_o = (state_q == S_OUT);
    fetching    = (state_q == S_FETCH_FULL) || (state_q == S_FETCH_COL);
    mem_row_o   = last_row_q;
    mem_col_o   = last_col_q;
    case (state_q)
      S_FETCH_FULL: begin
        mem_row_o = cr_q - ROW_ONE + RW'(row_off);
        mem_col_o = cc_q - COL_ONE + CW'(col_off);
      end
      S_FETCH_COL: begin
        mem_row_o = cr_q - ROW_ONE + RW'(idx_q);
        mem_col_o = cc_q + COL_ONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    cr_d       = cr_q;
    cc_d       = cc_q;
    win_d      = win_q;
    done_d     = 1'b0;
    last_row_d = fetching ? mem_row_o : last_row_q;
    last_col_d = fetching ? mem_col_o : last_col_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d = 4'd0;
          cr_d  = ROW_ONE;
          cc_d  = COL_ONE;
        end
      end
      S_FETCH_FULL: begin
        win_d[int'(idx_q)*DW +: DW] = mem_pixel_i;
        idx_d = (idx_q == IDX_FULL_LAST) ? 4'd0 : idx_q + 4'd1;
      end
      S_FETCH_COL: begin
        // Shift on the first column read; the new pixel then overwrites the right column slot.
        if (idx_q == 4'd0) begin
          for (int r = 0; r < 3; r++) begin
            win_d[(3*r)*DW +: DW]   = win_q[(3*r+1)*DW +: DW];
            win_d[(3*r+1)*DW +: DW] = win_q[(3*r+2)*DW +: DW];
          end
        end
        win_d[(3*int'(idx_q)+2)*DW +: DW] = mem_pixel_i;
        idx_d = (idx_q == IDX_COL_LAST) ? 4'd0 : idx_q + 4'd1;
      end
      S_OUT: begin
        if (win_ready_i) begin
          idx_d = 4'd0;
          if (cc_q < COL_LAST) begin
            cc_d = cc_q + COL_ONE;
          end else if (cr_q < ROW_LAST) begin
            cr_d = cr_q + ROW_ONE;
            cc_d = COL_ONE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q      <= '0;
      cr_q       <= '0;
      cc_q       <= '0;
      win_q      <= '0;
      done_q     <= 1'b0;
      last_row_q <= '0;
      last_col_q <= '0;
    end else begin
      idx_q      <= idx_d;
      cr_q       <= cr_d;
      cc_q       <= cc_d;
      win_q      <= win_d;
      done_q     <= done_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
    end
  end

  assign done_o     = done_q;
  assign win_data_o = win_q;
  assign win_row_o  = cr_q;
  assign win_col_o  = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sobel_window_fetch : self-checking bench for sobel_window_fetch          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_sobel_window_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ready, busy, done, valid;
  logic [2:0]  mrow, mcol, wrow, wcol;
  logic [7:0]  mpix;
  logic [71:0] wdata;

  logic        start3, ready3, busy3, done3, valid3;
  logic [1:0]  mrow3, mcol3, wrow3, wcol3;
  logic [7:0]  mpix3;
  logic [71:0] wdata3;

  // Image memory: pixel(i,j) = (i*j) % 256, combinational read
  assign mpix  = {5'd0, mrow} * {5'd0, mcol};
  assign mpix3 = {6'd0, mrow3} * {6'd0, mcol3};

  sobel_window_fetch #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_row_o(mrow), .mem_col_o(mcol), .mem_pixel_i(mpix),
    .win_valid_o(valid), .win_ready_i(ready), .win_data_o(wdata),
    .win_row_o(wrow), .win_col_o(wcol)
  );

  sobel_window_fetch #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .busy_o(busy3), .done_o(done3),
    .mem_row_o(mrow3), .mem_col_o(mcol3), .mem_pixel_i(mpix3),
    .win_valid_o(valid3), .win_ready_i(ready3), .win_data_o(wdata3),
    .win_row_o(wrow3), .win_col_o(wcol3)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(((r - 1 + k / 3) * (c - 1 + k % 3)) % 256);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for win_valid; optionally pulses start at random meanwhile.
  task automatic wait_valid(input bit rnd_start, output int lat);
    lat = 0;
    while (valid !== 1'b1 && lat < 40) begin
      if (rnd_start) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("valid_timeout", 72'(valid), 72'(1));
  endtask

  task automatic chk_window(input string tag, input int r, input int c);
    chk({tag, "_row"}, 72'(wrow), 72'(r));
    chk({tag, "_col"}, 72'(wcol), 72'(c));
    chk({tag, "_data"}, wdata, exp_win(r, c));
    chk({tag, "_mem"}, 72'({mrow, mcol}), 72'({3'(r + 1), 3'(c + 1)}));
  endtask

  int r, c, lat, stall, cnt, nv3;

  initial begin
    rst = 1'b0; start = 1'b1; ready = 1'b1; start3 = 1'b0; ready3 = 1'b1;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk("rst_busy",  72'(busy),  72'(0));
    chk("rst_done",  72'(done),  72'(0));
    chk("rst_valid", 72'(valid), 72'(0));
    chk("rst_mem",   72'({mrow, mcol}), 72'(0));
    chk("rst_wpos",  72'({wrow, wcol}), 72'(0));
    chk("rst_data",  wdata, 72'(0));
    rst = 1'b1; start = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy",  72'(busy),  72'(0));
    chk("idle_valid", 72'(valid), 72'(0));

    // Full scan, ready high except a 5-cycle stall on the second window
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int w = 0; w < 36; w++) begin
      r = 1 + w / 6; c = 1 + w % 6;
      wait_valid(1'b0, lat);
      chk("scan_lat", 72'(lat), 72'((c == 1) ? 9 : 3));
      chk("scan_busy", 72'(busy), 72'(1));
      chk_window("scan", r, c);
      if (w == 1) begin
        ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 72'(valid), 72'(1));
          chk_window("stall", r, c);
        end
        ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("end_done",  72'(done),  72'(1));
    chk("end_busy",  72'(busy),  72'(0));
    chk("end_valid", 72'(valid), 72'(0));
    @(negedge clk);
    chk("done_pulse", 72'(done), 72'(0));
    repeat (3) @(negedge clk);
    chk("post_valid", 72'(valid), 72'(0));

    // Random stalls and stray start pulses; reset on the 10th window
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int w = 0; w < 10; w++) begin
      r = 1 + w / 6; c = 1 + w % 6;
      wait_valid(1'b1, lat);
      chk("rnd_lat", 72'(lat), 72'((c == 1) ? 9 : 3));
      chk_window("rnd", r, c);
      if (w == 9) begin
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",  72'(busy),  72'(0));
        chk("abort_done",  72'(done),  72'(0));
        chk("abort_valid", 72'(valid), 72'(0));
        chk("abort_pos",   72'({wrow, wcol, mrow, mcol}), 72'(0));
        chk("abort_data",  wdata, 72'(0));
        rst = 1'b1;
      end else begin
        stall = int'($urandom_range(0, 3));
        ready = 1'b0;
        repeat (stall) begin
          start = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk_window("rnd_stall", r, c);
        end
        ready = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("abort_idle", 72'(busy), 72'(0));

    // Restart after abort begins again at centre (1,1)
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_valid(1'b0, lat);
    chk("restart_lat", 72'(lat), 72'(9));
    chk_window("restart", 1, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // 3x3 image: one window, busy for exactly 10 cycles
    start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    cnt = 0; nv3 = 0;
    while (busy3 === 1'b1 && cnt < 40) begin
      if (valid3 === 1'b1) begin
        nv3++;
        chk("s3_data", wdata3, exp_win(1, 1));
        chk("s3_pos",  72'({wrow3, wcol3}), 72'({2'd1, 2'd1}));
      end
      cnt++;
      @(negedge clk);
    end
    chk("s3_busy_cycles", 72'(cnt), 72'(10));
    chk("s3_windows", 72'(nv3), 72'(1));
    chk("s3_done", 72'(done3), 72'(1));
    @(negedge clk);
    chk("s3_done_pulse", 72'(done3), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
